// File: rtl/segre_scoreboard.sv
// rtl/segre_scoreboard.sv - register-hazard scoreboard and issue controller for the Segre decode stage
//
// Tracks architectural registers with a write in flight and the number of
// outstanding loads, and raises a combinational stall when the instruction in
// ID cannot issue.
//
// Ports:
//   clk_i           - clock, all state updates on the rising edge
//   rsn_i           - synchronous reset, active-high
//   id_valid_i      - ID holds a valid decoded instruction
//   id_rs1_i/_used  - source A address / read enable
//   id_rs2_i/_used  - source B address / read enable
//   id_rd_i, id_we_i- destination address / write enable
//   id_load_i       - instruction is a memory read
//   wb_valid_i      - register-file write this cycle, to wb_rd_i
//   mem_done_i      - one outstanding load completed
//   flush_i         - pipeline squash, discards all in-flight writes
//   hazard_o        - stall request to ID/IF (combinational)
//   issue_o         - ID instruction advances this cycle (combinational)
//   pending_o       - pending-write vector
//   loads_o         - outstanding load count
//   stall_cycles_o  - saturating count of cycles with hazard_o high
module segre_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_SIZE  = 5,
  parameter int MAX_LOADS = 2,
  localparam int LOAD_W   = $clog2(MAX_LOADS + 1)
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                id_valid_i,
  input  logic [REG_SIZE-1:0] id_rs1_i,
  input  logic                id_rs1_used_i,
  input  logic [REG_SIZE-1:0] id_rs2_i,
  input  logic                id_rs2_used_i,
  input  logic [REG_SIZE-1:0] id_rd_i,
  input  logic                id_we_i,
  input  logic                id_load_i,
  input  logic                wb_valid_i,
  input  logic [REG_SIZE-1:0] wb_rd_i,
  input  logic                mem_done_i,
  input  logic                flush_i,
  output logic                hazard_o,
  output logic                issue_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [LOAD_W-1:0]   loads_o,
  output logic [31:0]         stall_cycles_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [LOAD_W-1:0]   loads_q, loads_d;
  logic [31:0]         stall_q, stall_d;

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eff;
  logic                rd_nz;
  logic                raw_haz, waw_haz, str_haz;
  logic                load_inc;

  // Writeback happens before the register-file read, so a register being
  // written back this cycle no longer counts as pending for the ID instruction.
  always_comb begin
    wb_mask = '0;
    if (wb_valid_i) wb_mask[wb_rd_i] = 1'b1;
  end

  assign eff     = pending_q & ~wb_mask;
  assign rd_nz   = (id_rd_i != '0);
  assign raw_haz = (id_rs1_used_i & eff[id_rs1_i]) | (id_rs2_used_i & eff[id_rs2_i]);
  assign waw_haz = id_we_i & rd_nz & eff[id_rd_i];
  // A full load counter stalls even if a load completes this same cycle; this
  // keeps the counter free of a same-cycle bypass path.
  assign str_haz = id_load_i & (loads_q == LOAD_W'(MAX_LOADS));

  assign hazard_o = id_valid_i & ~flush_i & (raw_haz | waw_haz | str_haz);
  assign issue_o  = id_valid_i & ~flush_i & ~hazard_o;

  always_comb begin
    set_mask = '0;
    if (issue_o && id_we_i && rd_nz) set_mask[id_rd_i] = 1'b1;
  end

  assign load_inc = issue_o & id_load_i;

  always_comb begin
    // Set is applied after clear so a same-cycle issue and writeback to one
    // register leaves it pending.
    pending_d = flush_i ? '0 : ((pending_q & ~wb_mask) | set_mask);
    pending_d[0] = 1'b0;

    loads_d = loads_q;
    if (flush_i) begin
      loads_d = '0;
    end else if (load_inc && !mem_done_i) begin
      loads_d = loads_q + LOAD_W'(1);
    end else if (!load_inc && mem_done_i && loads_q != '0) begin
      loads_d = loads_q - LOAD_W'(1);
    end

    stall_d = stall_q;
    if (hazard_o && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      pending_q <= '0;
      loads_q   <= '0;
      stall_q   <= '0;
    end else begin
      pending_q <= pending_d;
      loads_q   <= loads_d;
      stall_q   <= stall_d;
    end
  end

  assign pending_o      = pending_q;
  assign loads_o        = loads_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_segre_scoreboard.sv
// tb/tb_segre_scoreboard.sv - self-checking bench for segre_scoreboard
module tb_segre_scoreboard;

  logic        clk = 1'b0;
  logic        rsn;
  logic        id_valid, id_rs1_used, id_rs2_used, id_we, id_load;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        wb_valid, mem_done, flush;
  logic        hazard, issue;
  logic [31:0] pending;
  logic [1:0]  loads;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, updated from the specification's rules.
  bit [31:0] m_pend;
  int        m_loads;
  longint    m_stall;

  always #5 clk = ~clk;

  segre_scoreboard dut (
    .clk_i          (clk),
    .rsn_i          (rsn),
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs1_used_i  (id_rs1_used),
    .id_rs2_i       (id_rs2),
    .id_rs2_used_i  (id_rs2_used),
    .id_rd_i        (id_rd),
    .id_we_i        (id_we),
    .id_load_i      (id_load),
    .wb_valid_i     (wb_valid),
    .wb_rd_i        (wb_rd),
    .mem_done_i     (mem_done),
    .flush_i        (flush),
    .hazard_o       (hazard),
    .issue_o        (issue),
    .pending_o      (pending),
    .loads_o        (loads),
    .stall_cycles_o (stall_cycles)
  );

  // Register r still awaits its write, as seen by the instruction in ID.
  function automatic bit busy(int r);
    return r != 0 && m_pend[r] && !(wb_valid && int'(wb_rd) == r);
  endfunction

  function automatic bit exp_hazard();
    bit raw, waw, full;
    raw  = (id_rs1_used && busy(int'(id_rs1))) || (id_rs2_used && busy(int'(id_rs2)));
    waw  = id_we && busy(int'(id_rd));
    full = id_load && m_loads == 2;
    return id_valid && !flush && (raw || waw || full);
  endfunction

  function automatic bit exp_issue();
    return id_valid && !flush && !exp_hazard();
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 0; id_we = 0; id_load = 0; wb_valid = 0; wb_rd = 0;
    mem_done = 0; flush = 0;
  endtask

  // Advance one clock edge and move the reference model along with it.
  task automatic tick();
    bit h, i;
    h = exp_hazard();
    i = exp_issue();
    @(posedge clk);
    if (rsn) begin
      m_pend = 0; m_loads = 0; m_stall = 0;
    end else begin
      if (h && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (flush) begin
        m_pend = 0; m_loads = 0;
      end else begin
        if (wb_valid) m_pend[wb_rd] = 0;
        if (i && id_we && id_rd != 0) m_pend[id_rd] = 1;
        m_loads = m_loads + ((i && id_load) ? 1 : 0) - (mem_done ? 1 : 0);
        if (m_loads < 0) m_loads = 0;
      end
    end
    #1;
  endtask

  task automatic issue_op(int rd, bit we, bit ld);
    idle();
    id_valid = 1; id_rd = 5'(rd); id_we = we; id_load = ld;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rsn = 1;
    tick(); tick();
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL reset_pending got=%h exp=0", pending); end
    n_cmp++; if (loads !== 2'd0) begin n_err++; $display("FAIL reset_loads got=%0d exp=0", loads); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    rsn = 0;
    issue_op(5, 1, 1);
    n_cmp++; if (pending !== 32'h20 || loads !== 2'd1) begin n_err++; $display("FAIL reset_setup pend=%h loads=%0d exp pend=20 loads=1", pending, loads); end
    idle();
    id_valid = 1; id_load = 1; id_rd = 6; id_we = 1; wb_valid = 1; wb_rd = 5; rsn = 1;
    #1;
    n_cmp++; if (hazard !== 1'b0 || issue !== 1'b1) begin n_err++; $display("FAIL reset_comb hazard=%b issue=%b exp 0/1", hazard, issue); end
    tick();
    n_cmp++; if (pending !== 32'h0 || loads !== 2'd0 || stall_cycles !== 32'd0) begin
      n_err++; $display("FAIL reset_midop pend=%h loads=%0d stall=%0d exp all 0", pending, loads, stall_cycles); end
    rsn = 0;
    idle();
  endtask

  task automatic test_raw();
    issue_op(5, 1, 0);
    idle();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL raw_stall cyc=%0d hazard=%b exp=1", c, hazard); end
      tick();
    end
    wb_valid = 1; wb_rd = 5;
    #1;
    n_cmp++; if (hazard !== 1'b0 || issue !== 1'b1) begin n_err++; $display("FAIL raw_release hazard=%b issue=%b exp 0/1", hazard, issue); end
    tick();
    n_cmp++; if (stall_cycles !== 32'd3) begin n_err++; $display("FAIL raw_stall_count got=%0d exp=3", stall_cycles); end
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL raw_pending got=%h exp=0", pending); end
    idle();
  endtask

  task automatic test_x0();
    issue_op(0, 1, 0);
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL x0_pending got=%h exp=0", pending); end
    idle();
    id_valid = 1; id_rs1 = 0; id_rs1_used = 1;
    #1;
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL x0_read hazard=%b exp=0", hazard); end
    issue_op(7, 1, 0);
    idle();
    id_valid = 1; id_rs2 = 7; id_rs2_used = 0;
    #1;
    n_cmp++; if (hazard !== 1'b0 || issue !== 1'b1) begin n_err++; $display("FAIL unused_rs2 hazard=%b issue=%b exp 0/1", hazard, issue); end
    idle();
    wb_valid = 1; wb_rd = 7;
    tick();
    idle();
  endtask

  task automatic test_same_cycle();
    issue_op(9, 1, 0);
    idle();
    id_valid = 1; id_rd = 9; id_we = 1; wb_valid = 1; wb_rd = 9;
    #1;
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL same_cycle_issue got=%b exp=1", issue); end
    tick();
    n_cmp++; if (pending[9] !== 1'b1) begin n_err++; $display("FAIL same_cycle_pending9 got=%b exp=1", pending[9]); end
    idle();
    wb_valid = 1; wb_rd = 9;
    tick();
    idle();
  endtask

  task automatic test_load_capacity();
    issue_op(0, 0, 1);
    issue_op(0, 0, 1);
    n_cmp++; if (loads !== 2'd2) begin n_err++; $display("FAIL load_two got=%0d exp=2", loads); end
    idle(); id_valid = 1; id_load = 1;
    #1;
    n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL load_full hazard=%b exp=1", hazard); end
    tick();
    mem_done = 1;
    #1;
    n_cmp++; if (hazard !== 1'b1 || issue !== 1'b0) begin n_err++; $display("FAIL load_full_done hazard=%b issue=%b exp 1/0", hazard, issue); end
    tick();
    n_cmp++; if (loads !== 2'd1) begin n_err++; $display("FAIL load_after_done got=%0d exp=1", loads); end
    mem_done = 0;
    #1;
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL load_third_issue got=%b exp=1", issue); end
    tick();
    n_cmp++; if (loads !== 2'd2) begin n_err++; $display("FAIL load_third_count got=%0d exp=2", loads); end
    idle(); mem_done = 1;
    tick(); tick(); tick();
    n_cmp++; if (loads !== 2'd0) begin n_err++; $display("FAIL load_no_underflow got=%0d exp=0", loads); end
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] s_before;
    issue_op(3, 1, 1);
    issue_op(4, 1, 1);
    idle(); id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
    #1;
    n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL flush_pre_stall hazard=%b exp=1", hazard); end
    tick();
    s_before = 32'(m_stall);
    flush = 1;
    #1;
    n_cmp++; if (hazard !== 1'b0 || issue !== 1'b0) begin n_err++; $display("FAIL flush_comb hazard=%b issue=%b exp 0/0", hazard, issue); end
    tick();
    n_cmp++; if (pending !== 32'h0 || loads !== 2'd0) begin n_err++; $display("FAIL flush_state pend=%h loads=%0d exp 0/0", pending, loads); end
    n_cmp++; if (stall_cycles !== s_before) begin n_err++; $display("FAIL flush_stall_kept got=%0d exp=%0d", stall_cycles, s_before); end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs1_used = $urandom_range(0, 1) == 1;
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs2_used = $urandom_range(0, 1) == 1;
      id_rd       = 5'($urandom_range(0, 7));
      id_we       = $urandom_range(0, 1) == 1;
      id_load     = $urandom_range(0, 2) == 0;
      wb_valid    = $urandom_range(0, 1) == 1;
      wb_rd       = 5'($urandom_range(0, 7));
      mem_done    = m_loads > 0 && $urandom_range(0, 2) == 0;
      flush       = $urandom_range(0, 29) == 0;
      rsn         = $urandom_range(0, 99) == 0;
      #1;
      n_cmp++; if (hazard !== exp_hazard()) begin n_err++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", c, hazard, exp_hazard()); end
      n_cmp++; if (issue !== exp_issue()) begin n_err++; $display("FAIL rnd_issue cyc=%0d got=%b exp=%b", c, issue, exp_issue()); end
      tick();
      n_cmp++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", c, pending, m_pend); end
      n_cmp++; if (int'(loads) !== m_loads) begin n_err++; $display("FAIL rnd_loads cyc=%0d got=%0d exp=%0d", c, loads, m_loads); end
      n_cmp++; if (stall_cycles !== 32'(m_stall)) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", c, stall_cycles, m_stall); end
    end
    rsn = 0;
    idle();
  endtask

  initial begin
    m_pend = 0; m_loads = 0; m_stall = 0;
    rsn = 1;
    idle();
    #1;
    test_reset();
    test_raw();
    test_x0();
    test_same_cycle();
    test_load_capacity();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/segre_scoreboard.md
# segre_scoreboard

Register-hazard scoreboard and issue controller for the Segre decode stage. Tracks every architectural register with a write still in flight, and tracks the number of outstanding loads. Produces the `hazard` stall that freezes the ID/EX pipeline register and the fetch path. Sits beside the ID stage: it takes decode-time register usage and issues from ID, and writeback and memory-completion events from the back end.

## Interface
- `NUM_REGS`, 32: architectural registers. Register 0 is hardwired zero and is never tracked.
- `REG_SIZE`, 5: register address width, equal to clog2(`NUM_REGS`).
- `MAX_LOADS`, 2: maximum loads in flight between issue and memory completion.
- `clk_i` input 1: single clock. All state updates on its rising edge.
- `rsn_i` input 1: reset, synchronous, active-high. The port keeps the codebase name; its polarity is high.
- `id_valid_i` input 1: the ID stage holds a valid decoded instruction this cycle.
- `id_rs1_i` input `REG_SIZE`: source register A address.
- `id_rs1_used_i` input 1: the instruction reads rs1.
- `id_rs2_i` input `REG_SIZE`: source register B address.
- `id_rs2_used_i` input 1: the instruction reads rs2.
- `id_rd_i` input `REG_SIZE`: destination register address.
- `id_we_i` input 1: the instruction writes rd.
- `id_load_i` input 1: the instruction is a memory read.
- `wb_valid_i` input 1: a register-file write occurs this cycle.
- `wb_rd_i` input `REG_SIZE`: the writeback register address.
- `mem_done_i` input 1: one outstanding load has completed at the memory side.
- `flush_i` input 1: pipeline squash. All in-flight writes are discarded.
- `hazard_o` output 1: stall request to the ID/IF stages (combinational).
- `issue_o` output 1: the ID instruction advances this cycle (combinational).
- `pending_o` output `NUM_REGS`: current pending-write vector, for debug and assertions.
- `loads_o` output clog2(`MAX_LOADS`+1): outstanding load count.
- `stall_cycles_o` output 32: saturating count of cycles with `hazard_o`=1.

## Operation
- **State.**
  - `pending[NUM_REGS-1:0]`.
  - Load counter `loads`.
  - Counter `stall_cycles`.
  - `pending[0]` is constant 0.
- **Effective pending.** `eff(r)` = `pending[r]` AND NOT (`wb_valid_i` AND `wb_rd_i`==r). The register file writes before it reads, so a writeback clears its hazard in the same cycle.
- **RAW hazard.** (`id_rs1_used_i` AND `eff(rs1)`) OR (`id_rs2_used_i` AND `eff(rs2)`).
- **WAW hazard.** `id_we_i` AND rd≠0 AND `eff(rd)`.
- **Structural hazard.** `id_load_i` AND `loads`==`MAX_LOADS`.
  - This holds even when `mem_done_i`=1 in the same cycle, so the counter never needs a same-cycle bypass.
- **`hazard_o`.** `id_valid_i` AND NOT `flush_i` AND (RAW OR WAW OR structural).
- **`issue_o`.** `id_valid_i` AND NOT `flush_i` AND NOT `hazard_o`.
- **Pending update, next state, in priority order.**
  - If `flush_i`: all bits are 0.
  - Otherwise, each bit is cleared by `wb_valid_i` addressing it.
  - An issuing instruction with `id_we_i`=1 and rd≠0 sets `pending[rd]`.
  - When an issue and a writeback hit the same register in the same cycle, the set wins.
  - A writeback to a non-pending register, or to x0, has no effect.
- **Load counter update.**
  - If `flush_i`: 0.
  - Otherwise: `loads` + (`issue_o` AND `id_load_i`) − `mem_done_i`.
  - Increment and decrement in the same cycle leaves the count unchanged.
  - `mem_done_i` with `loads`==0 is ignored; the counter never underflows.
- **Stall counter.** Increments on every cycle with `hazard_o`=1 and saturates at 0xFFFF_FFFF. `flush_i` does not clear it.
- **Write-after-issue.** Writes sourced from an instruction already issued before a flush must not raise `wb_valid_i` afterwards; the back end guarantees this. The scoreboard does not filter them.

## Timing
- **Reset** (sampled at an edge while `rsn_i`=1):
  - `pending_o`=0, `loads_o`=0, `stall_cycles_o`=0.
  - `hazard_o`=0, since pending is clear; `issue_o` follows `id_valid_i`.
  - Reset overrides flush, issue and writeback in the same cycle.
- **Combinational outputs.** `hazard_o` and `issue_o` are combinational from the inputs and current state, with zero-cycle latency.
- **Issue visibility.** A pending bit set by an issue at edge N is visible to the instruction in ID during cycle N+1. Back-to-back dependent instructions therefore stall at least until the producer's writeback cycle, and issue in that cycle.
- **Flush.** When `flush_i` is asserted in cycle N, `hazard_o`=0 and `issue_o`=0 in cycle N, and state is cleared at the end of cycle N.
- **Outputs.** `pending_o` and `loads_o` reflect registered state and change only at clock edges.

## Test plan
- **Reset mid-operation.**
  - Stimulus: set `pending[5]` and `loads`=1, then assert `rsn_i` together with `id_valid_i`, a load issue and `wb_valid_i`.
  - Required response: after the edge, `pending_o`=0, `loads_o`=0 and `stall_cycles_o`=0.
- **RAW stall and release.**
  - Stimulus: issue with rd=5 and `id_we_i`=1. Next cycle present rs1=5 used → `hazard_o`=1. Hold it for 3 cycles, then apply `wb_valid_i`, `wb_rd_i`=5.
  - Required response: `hazard_o`=0 and `issue_o`=1 in the writeback cycle, and `stall_cycles_o`=3.
- **x0 and unused sources.**
  - Stimulus: issue with rd=0; the next instruction reads rs1=0. Separately, an instruction with rs2=7 pending but `id_rs2_used_i`=0.
  - Required response: `pending_o`=0 after the rd=0 issue, and `hazard_o`=0 in both cases.
- **Same-cycle set/clear of one register.**
  - Stimulus: `pending[9]`=1; `wb_rd_i`=9 and an issue with rd=9 occur in the same cycle.
  - Required response: `issue_o`=1, and `pending[9]`=1 afterwards.
- **Load capacity.**
  - Stimulus: issue 2 loads → `loads_o`=2. A third load → `hazard_o`=1, including while `mem_done_i`=1. Then one cycle with `loads_o`=1.
  - Required response: the third load issues and `loads_o`=2. With `loads_o`=0, `mem_done_i` leaves the counter at 0.
- **Flush.**
  - Stimulus: `pending[3]`, `pending[4]` set, `loads`=2, and a stalled instruction in ID; assert `flush_i`.
  - Required response: `hazard_o`=0 and `issue_o`=0 in that cycle, then `pending_o`=0 and `loads_o`=0. `stall_cycles_o` is preserved.
